// File: rtl/sha256_pkg.sv
// sha256_pkg: FSM state encoding, SHA-256 initial hash values and padding constants shared by the stream controller
package sha256_pkg;
  typedef enum logic [2:0] {IDLE, FILL, PAD, START, WAIT, OUT} state_t;
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam logic [5:0] LEN_FIT_BYTES = 6'd55;
endpackage

// File: rtl/sha256_pad_word.sv
// sha256_pad_word: combinational padding word generator
//   idx       word index within the block being built
//   pad_done  0x80 byte already placed; len_ok the length words belong in this block
//   byte_cnt  message length in bytes; data/bytes the final message word and its valid byte count
//   pad_word  word PAD writes at idx; last_word final word with 0x80 merged after the valid bytes
//   pad_fits / last_fits  the 0x80 byte written now lands at or before the length-fit threshold
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [3:0]  idx,
  input  logic        pad_done,
  input  logic        len_ok,
  input  logic [60:0] byte_cnt,
  input  logic [31:0] data,
  input  logic [1:0]  bytes,
  output logic [31:0] pad_word,
  output logic [31:0] last_word,
  output logic        pad_fits,
  output logic        last_fits
);
  logic [63:0] bit_len;
  logic [4:0]  sh;
  assign bit_len = {byte_cnt, 3'b000};
  assign sh = {bytes, 3'b000};
  assign pad_word = !pad_done ? {PAD_BYTE, 24'h0} :
                    len_ok && idx == 4'd14 ? bit_len[63:32] :
                    len_ok && idx == 4'd15 ? bit_len[31:0] : 32'h0;
  // keep the left-justified valid bytes, drop 0x80 into the first invalid byte
  assign last_word = bytes == 2'd0 ? data : (data & ~(32'hffff_ffff >> sh)) | ({PAD_BYTE, 24'h0} >> sh);
  assign pad_fits = {idx, 2'b00} <= LEN_FIT_BYTES;
  assign last_fits = {idx, 2'b00} + 6'(bytes) <= LEN_FIT_BYTES;
endmodule

// File: rtl/sha256_stream_ctrl.sv
// sha256_stream_ctrl: streams message words into 512-bit blocks, pads them and sequences an external SHA-256 core
//   in_valid/in_data/in_last/in_bytes/in_ready  word stream input, big-endian, final word may be partial
//   core_start/core_first_run/core_block        block hand-off to the core; core_ready/core_hash its result
//   digest_valid/digest/digest_ready            final digest handshake; busy high outside IDLE
module sha256_stream_ctrl
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [1:0]   in_bytes,
  output logic         in_ready,
  output logic         core_start,
  output logic         core_first_run,
  output logic [511:0] core_block,
  input  logic         core_ready,
  input  logic [255:0] core_hash,
  output logic         digest_valid,
  output logic [255:0] digest,
  input  logic         digest_ready,
  output logic         busy
);
  state_t            state;
  logic [0:15][31:0] blk;
  logic [3:0]        idx;
  logic [60:0]       byte_cnt;
  logic              ended, pad_done, len_ok, first, skip;
  logic [31:0]       pad_word, last_word;
  logic              pad_fits, last_fits, accept, part;
  assign in_ready = (state == IDLE || state == FILL) && !rst;
  assign accept = in_valid && in_ready;
  assign part = in_last && in_bytes != 2'd0;
  assign busy = state != IDLE;
  assign core_block = blk;
  sha256_pad_word u_pad (
    .idx       (idx),
    .pad_done  (pad_done),
    .len_ok    (len_ok),
    .byte_cnt  (byte_cnt),
    .data      (in_data),
    .bytes     (in_bytes),
    .pad_word  (pad_word),
    .last_word (last_word),
    .pad_fits  (pad_fits),
    .last_fits (last_fits)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      blk <= '0;
      idx <= '0;
      byte_cnt <= '0;
      ended <= 1'b0;
      pad_done <= 1'b0;
      len_ok <= 1'b0;
      first <= 1'b1;
      skip <= 1'b0;
      core_start <= 1'b0;
      core_first_run <= 1'b0;
      digest_valid <= 1'b0;
      digest <= '0;
    end else begin
      core_start <= 1'b0;
      core_first_run <= 1'b0;
      case (state)
        IDLE, FILL: if (accept) begin
          blk[idx] <= part ? last_word : in_data;
          byte_cnt <= byte_cnt + (part ? 61'(in_bytes) : 61'd4);
          idx <= idx + 4'd1;
          ended <= in_last;
          pad_done <= part;
          len_ok <= part && last_fits;
          if (idx == 4'd15) begin
            state <= START;
            core_start <= 1'b1;
            core_first_run <= first;
          end else
            state <= in_last ? PAD : FILL;
        end
        PAD: begin
          blk[idx] <= pad_word;
          idx <= idx + 4'd1;
          if (!pad_done) begin
            pad_done <= 1'b1;
            len_ok <= pad_fits;
          end
          if (idx == 4'd15) begin
            state <= START;
            core_start <= 1'b1;
            core_first_run <= first;
          end
        end
        START: begin
          state <= WAIT;
          skip <= 1'b1;
        end
        // the core may still show its previous done flag right after the start pulse
        WAIT: if (skip)
          skip <= 1'b0;
        else if (core_ready) begin
          if (len_ok) begin
            digest <= core_hash;
            digest_valid <= 1'b1;
            state <= OUT;
          end else begin
            // a placed 0x80 that did not fit leaves only zeros and the length for the next block
            blk <= '0;
            idx <= '0;
            first <= 1'b0;
            len_ok <= pad_done;
            state <= ended ? PAD : FILL;
          end
        end
        OUT: if (digest_ready) begin
          digest_valid <= 1'b0;
          state <= IDLE;
          blk <= '0;
          idx <= '0;
          byte_cnt <= '0;
          ended <= 1'b0;
          pad_done <= 1'b0;
          len_ok <= 1'b0;
          first <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_stream_ctrl.sv
// tb_sha256_stream_ctrl: randomized self-checking bench with a behavioural SHA-256 core and byte-level reference model
module tb_sha256_stream_ctrl;
  localparam logic [255:0] H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] S56_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam int LENS [12] = '{1, 3, 4, 55, 56, 57, 63, 64, 65, 119, 120, 128};
  string s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, digest_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0] in_bytes = '0;
  logic in_ready, core_start, core_first_run, core_ready, digest_valid, busy;
  logic [511:0] core_block;
  logic [255:0] core_hash, digest;
  int n_chk = 0, n_fail = 0, n_moved = 0, ccnt;
  logic cdrop, cfirst, stuck = 1'b0;
  logic [511:0] csnap;
  logic fr_q[$];
  logic [511:0] blk_q[$];
  logic [7:0] msg[$];
  sha256_stream_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
    .in_ready(in_ready), .core_start(core_start), .core_first_run(core_first_run), .core_block(core_block),
    .core_ready(core_ready), .core_hash(core_hash), .digest_valid(digest_valid), .digest(digest),
    .digest_ready(digest_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] b);
    logic [31:0] w [0:63];
    logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    {a, bb, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + bb, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction
  function automatic logic [255:0] sha_ref(input logic [7:0] m[$]);
    logic [7:0] p[$];
    logic [63:0] bl;
    logic [255:0] h;
    logic [511:0] b;
    p = m;
    bl = 64'(m.size()) << 3;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    h = H0;
    for (int k = 0; k < p.size() / 64; k++) begin
      for (int j = 0; j < 64; j++) b[511 - 8*j -: 8] = p[64*k + j];
      h = compress(h, b);
    end
    return h;
  endfunction
  // core stand-in: done flag falls one cycle after the start pulse, random latency, hashes the live block at the end
  always @(posedge clk) begin
    if (rst) begin
      core_ready <= 1'b1;
      ccnt <= 0;
      cdrop <= 1'b0;
      cfirst <= 1'b0;
      core_hash <= '0;
    end else begin
      cdrop <= 1'b0;
      if (cdrop) core_ready <= 1'b0;
      if (ccnt > 0 && core_block !== csnap) n_moved++;
      if (core_start) begin
        ccnt <= $urandom_range(20, 80);
        cdrop <= 1'b1;
        cfirst <= core_first_run;
        csnap <= core_block;
        fr_q.push_back(core_first_run);
        blk_q.push_back(core_block);
      end else if (ccnt == 1) begin
        core_hash <= compress(cfirst ? H0 : core_hash, core_block);
        core_ready <= 1'b1;
        ccnt <= 0;
      end else if (ccnt > 1)
        ccnt <= ccnt - 1;
    end
  end
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] b);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l; in_bytes = b;
    while (!in_ready && !stuck && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      stuck = 1'b1;
    end
    @(posedge clk);
    #1 in_valid = 1'b0; in_data = $urandom; in_last = 1'($urandom); in_bytes = 2'($urandom);
  endtask
  task automatic send_msg(input int gap);
    int n;
    logic [31:0] w;
    logic l;
    n = msg.size();
    for (int i = 0; i < n; i += 4) begin
      w = $urandom;
      l = i + 4 >= n;
      for (int j = 0; j < 4; j++) if (i + j < n) w[31 - 8*j -: 8] = msg[i + j];
      repeat ($urandom_range(0, gap)) @(negedge clk);
      send_word(w, l, l ? 2'(n % 4) : 2'($urandom));
    end
  endtask
  task automatic run_msg(input int gap, input int hold, output logic [255:0] dig);
    logic [255:0] exp;
    int b0, m0, t, nb;
    exp = sha_ref(msg);
    b0 = fr_q.size();
    m0 = n_moved;
    nb = (msg.size() + 8) / 64 + 1;
    send_msg(gap);
    t = 0;
    while (!digest_valid && !stuck && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!digest_valid) stuck = 1'b1;
    check("digest_valid", digest_valid, 1);
    dig = digest;
    if (hold > 0) begin
      in_valid = 1'b1; in_last = 1'b1; in_data = $urandom;
    end
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", digest_valid, 1);
      check("hold_digest", digest, exp);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    check("idle_after_hs", busy, 0);
    check("valid_after_hs", digest_valid, 0);
    check("digest", dig, exp);
    check("blocks", fr_q.size() - b0, nb);
    for (int i = b0; i < fr_q.size(); i++) check("first_run", fr_q[i], i == b0);
    check("block_stable", n_moved - m0, 0);
  endtask
  task automatic load_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask
  task automatic load_rand(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end
  initial begin
    logic [255:0] d;
    int b0, t;
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_digest_valid", digest_valid, 0);
    check("rst_digest", digest, 0);
    check("rst_core_start", core_start, 0);
    check("rst_first_run", core_first_run, 0);
    check("rst_core_block", core_block, 0);
    check("idle_in_ready", in_ready, 1);
    load_str("abc");
    run_msg(0, 20, d);
    check("abc_kat", d, ABC_DIG);
    run_msg(1, 0, d);
    check("abc_again_kat", d, ABC_DIG);
    load_str(s56);
    run_msg(1, 2, d);
    check("s56_kat", d, S56_DIG);
    load_rand(64);
    b0 = fr_q.size();
    run_msg(0, 1, d);
    check("pad_only_block", blk_q[b0 + 1], {32'h80000000, 416'h0, 64'h200});
    load_str(s56);
    b0 = fr_q.size();
    send_msg(0);
    t = 0;
    while (fr_q.size() == b0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("mid_start_seen", fr_q.size() - b0, 1);
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", digest_valid, 0);
    load_str("abc");
    run_msg(0, 0, d);
    check("abc_after_rst_kat", d, ABC_DIG);
    foreach (LENS[i]) begin
      load_rand(LENS[i]);
      run_msg($urandom_range(0, 2), $urandom_range(0, 3), d);
    end
    repeat (6) begin
      load_rand($urandom_range(1, 250));
      run_msg($urandom_range(0, 2), $urandom_range(0, 3), d);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
